// File: rtl/core_scheduler_if.sv
// Scheduler <-> dispatcher/datapath bundle: task start/done, fetch
// handshake, decoded-instruction flags, LSU busy and perf counters.
interface core_scheduler_if #(
    parameter int PC_BITS = 8,
    parameter int LANES   = 4
);
    logic               start;
    logic               done;
    logic               fetch_req;
    logic               fetch_valid;
    logic               decoded_mem_access;
    logic               decoded_ret;
    logic               decoded_branch;
    logic [PC_BITS-1:0] branch_target;
    logic [LANES-1:0]   lsu_busy;
    logic [2:0]         core_state;
    logic [PC_BITS-1:0] current_pc;
    logic [15:0]        instr_retired;
    logic [15:0]        stall_cycles;

    modport master (
        input  start,
        input  fetch_valid,
        input  decoded_mem_access,
        input  decoded_ret,
        input  decoded_branch,
        input  branch_target,
        input  lsu_busy,
        output done,
        output fetch_req,
        output core_state,
        output current_pc,
        output instr_retired,
        output stall_cycles
    );

    modport slave (
        output start,
        output fetch_valid,
        output decoded_mem_access,
        output decoded_ret,
        output decoded_branch,
        output branch_target,
        output lsu_busy,
        input  done,
        input  fetch_req,
        input  core_state,
        input  current_pc,
        input  instr_retired,
        input  stall_cycles
    );
endinterface

// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: FETCH..UPDATE stepping, PC, stalls.
// Define SCHED_PERF_CNT_EN to build the retired/stall perf counters.
module core_scheduler #(
    parameter int                 PC_BITS  = 8,
    parameter int                 LANES    = 4,
    parameter logic [PC_BITS-1:0] START_PC = '0
) (
    input logic              clk,
    input logic              reset,
    core_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        REQUEST = 3'b011,
        WAIT    = 3'b100,
        EXECUTE = 3'b101,
        UPDATE  = 3'b110,
        DONE    = 3'b111
    } state_t;

    state_t             state_q, state_d;
    logic [PC_BITS-1:0] pc_q, pc_d;
    logic               done_q, done_d;
    logic               wait_q, wait_d;
    logic [LANES-1:0]   busy;

    assign busy = bus.lsu_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            done_q  <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            wait_q  <= wait_d;
        end
    end

    // wait_q marks WAIT cycles after the LSU issue cycle
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        wait_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    pc_d    = START_PC;
                end
            end
            FETCH: begin
                if (bus.fetch_valid) state_d = DECODE;
            end
            DECODE:  state_d = REQUEST;
            REQUEST: state_d = WAIT;
            WAIT: begin
                if (!bus.decoded_mem_access ||
                    (wait_q && busy == '0)) begin
                    state_d = EXECUTE;
                end else begin
                    wait_d = 1'b1;
                end
            end
            EXECUTE: state_d = UPDATE;
            UPDATE: begin
                if (bus.decoded_ret) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (bus.decoded_branch) begin
                    state_d = FETCH;
                    pc_d    = bus.branch_target;
                end else begin
                    state_d = FETCH;
                    pc_d    = pc_q + PC_BITS'(1);
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    pc_d    = START_PC;
                    done_d  = 1'b0;
                end
            end
        endcase
    end

    assign bus.core_state = state_q;
    assign bus.fetch_req  = (state_q == FETCH);
    assign bus.current_pc = pc_q;
    assign bus.done       = done_q;

`ifdef SCHED_PERF_CNT_EN
    logic [15:0] retired_q, stall_q;
    logic        accept, stall_tick;

    assign accept = bus.start &&
                    (state_q == IDLE || state_q == DONE);
    assign stall_tick = (state_q == FETCH && !bus.fetch_valid) ||
                        (state_q == WAIT && wait_q);

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (state_q == UPDATE && retired_q != 16'hFFFF)
                retired_q <= retired_q + 16'd1;
            if (stall_tick && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.instr_retired = retired_q;
    assign bus.stall_cycles  = stall_q;
`else
    assign bus.instr_retired = 16'h0000;
    assign bus.stall_cycles  = 16'h0000;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
// Directed + randomized bench for core_scheduler; expected state trace
// is built per instruction from its fetch/memory/branch parameters.
module tb_core_scheduler;

    localparam int         PB      = 8;
    localparam logic [7:0] SPC     = 8'h05;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DEC   = 3'd2;
    localparam logic [2:0] S_REQ   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_EXE   = 3'd5;
    localparam logic [2:0] S_UPD   = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    core_scheduler_if #(.PC_BITS(PB), .LANES(4)) bus ();

    core_scheduler #(
        .PC_BITS (PB),
        .LANES   (4),
        .START_PC(SPC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int m_pc, m_ret, m_stall;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] perf(int v);
`ifdef SCHED_PERF_CNT_EN
        return (v > 65535) ? 32'hFFFF : 32'(v);
`else
        return 32'(v & 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cycle(string tag, logic [2:0] st);
        chk({tag, ".state"}, 32'(bus.core_state), 32'(st));
        chk({tag, ".fetch_req"}, 32'(bus.fetch_req), 32'(st == S_FETCH));
        chk({tag, ".done"}, 32'(bus.done), 32'(st == S_DONE));
        chk({tag, ".pc"}, 32'(bus.current_pc), 32'(m_pc));
    endtask

    task automatic chk_perf(string tag);
        chk({tag, ".retired"}, 32'(bus.instr_retired), perf(m_ret));
        chk({tag, ".stalls"}, 32'(bus.stall_cycles), perf(m_stall));
    endtask

    task automatic rand_dc();
        bus.start              = 1'($urandom);
        bus.fetch_valid        = 1'($urandom);
        bus.decoded_mem_access = 1'($urandom);
        bus.decoded_ret        = 1'($urandom);
        bus.decoded_branch     = 1'($urandom);
        bus.branch_target      = 8'($urandom);
        bus.lsu_busy           = 4'($urandom);
    endtask

    // One instruction starting with core_state observed in FETCH:
    // f fetch stalls, mem access with b busy cycles after the issue cycle.
    task automatic run_instr(int f, bit mem, int b, bit ret, bit br,
                             logic [7:0] tgt);
        int w;
        chk_perf("fetch_entry");
        for (int i = 0; i <= f; i++) begin
            chk_cycle("fetch", S_FETCH);
            rand_dc();
            bus.start       = 1'b1;
            bus.fetch_valid = (i == f);
            tick();
        end
        m_stall += f;
        chk_cycle("decode", S_DEC);
        rand_dc();
        tick();
        chk_cycle("request", S_REQ);
        rand_dc();
        tick();
        w = mem ? b + 2 : 1;
        for (int j = 0; j < w; j++) begin
            chk_cycle("wait", S_WAIT);
            rand_dc();
            bus.decoded_mem_access = mem;
            if (mem && j > 0)
                bus.lsu_busy = (j == w - 1) ? 4'b0000
                                            : 4'($urandom_range(1, 15));
            tick();
        end
        m_stall += w - 1;
        chk_cycle("execute", S_EXE);
        rand_dc();
        tick();
        chk_cycle("update", S_UPD);
        rand_dc();
        bus.decoded_ret    = ret;
        bus.decoded_branch = br;
        bus.branch_target  = tgt;
        tick();
        m_ret++;
        if (ret) begin
            chk_cycle("ret", S_DONE);
            chk_perf("ret");
        end else begin
            m_pc = br ? int'(tgt) : (m_pc + 1) % 256;
        end
    endtask

    task automatic restart(int k);
        for (int i = 0; i < k; i++) begin
            rand_dc();
            bus.start = 1'b0;
            tick();
            chk_cycle("done_hold", S_DONE);
        end
        rand_dc();
        bus.start = 1'b1;
        tick();
        m_pc    = SPC;
        m_ret   = 0;
        m_stall = 0;
    endtask

    initial begin
        m_pc    = SPC;
        m_ret   = 0;
        m_stall = 0;
        rand_dc();
        bus.start = 1'b1;
        reset     = 1'b1;
        tick();
        tick();
        chk_cycle("reset", S_IDLE);
        chk_perf("reset");

        reset     = 1'b0;
        bus.start = 1'b0;
        tick();
        tick();
        chk_cycle("idle_hold", S_IDLE);

        bus.start = 1'b1;
        tick();
        run_instr(0, 1'b0, 0, 1'b0, 1'b0, 8'h00);
        run_instr(0, 1'b1, 2, 1'b0, 1'b0, 8'h00);
        run_instr(2, 1'b0, 0, 1'b0, 1'b1, 8'hFF);
        run_instr(0, 1'b0, 0, 1'b0, 1'b0, 8'h00);
        chk("wrap_pc", 32'(bus.current_pc), 32'h00);
        run_instr(0, 1'b0, 0, 1'b0, 1'b1, 8'h40);
        chk("branch_pc", 32'(bus.current_pc), 32'h40);
        run_instr(1, 1'b1, 1, 1'b1, 1'b1, 8'h77);
        restart(2);
        chk_cycle("restart", S_FETCH);
        run_instr(5, 1'b0, 0, 1'b0, 1'b0, 8'h00);

        for (int n = 0; n < 60; n++) begin
            bit ret;
            ret = ($urandom_range(0, 7) == 0);
            run_instr($urandom_range(0, 3), 1'($urandom),
                      $urandom_range(0, 3), ret,
                      ($urandom_range(0, 2) == 0), 8'($urandom));
            if (ret) restart($urandom_range(0, 2));
        end

        chk_cycle("pre_abort", S_FETCH);
        rand_dc();
        bus.fetch_valid = 1'b1;
        tick();
        rand_dc();
        tick();
        rand_dc();
        tick();
        chk_cycle("abort_wait", S_WAIT);
        rand_dc();
        bus.decoded_mem_access = 1'b1;
        bus.lsu_busy           = 4'b1111;
        tick();
        chk_cycle("abort_wait2", S_WAIT);
        reset = 1'b1;
        tick();
        m_pc    = SPC;
        m_ret   = 0;
        m_stall = 0;
        chk_cycle("mid_reset", S_IDLE);
        chk_perf("mid_reset");
        reset     = 1'b0;
        bus.start = 1'b0;
        tick();
        chk_cycle("post_reset", S_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
Per-core instruction sequencer. It drives the 3-bit core_state bus consumed by the register file, ALU, LSU and fetcher. It steps each instruction through FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE, holds the program counter, and stalls on fetch and LSU latency. It sits between the task dispatcher (start/done) and the core datapath.

Parameters:
PC_BITS, 8, program counter width; PC wraps modulo 2^PC_BITS
LANES, 4, number of vector lanes/LSUs reporting busy
START_PC, 0, PC loaded at reset and at every accepted start

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  launch task; accepted only in IDLE or DONE
fetch_req  out  1  instruction fetch request
fetch_valid  in  1  fetched instruction ready this cycle
decoded_mem_access  in  1  current instruction is LDR/STR (scalar or vector)
decoded_ret  in  1  current instruction is RET
decoded_branch  in  1  branch taken
branch_target  in  PC_BITS  branch destination
lsu_busy  in  LANES  per-lane LSU outstanding flag
core_state  out  3  current state encoding
current_pc  out  PC_BITS  PC of instruction in flight
done  out  1  task finished
instr_retired  out  16  perf counter (see Optional Feature)
stall_cycles  out  16  perf counter (see Optional Feature)

Behaviour:
- Clock clk; reset is synchronous, active-high.
- State encoding: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111. REQUEST and UPDATE codes are fixed; the register file reads in REQUEST and writes in UPDATE.
- Reset, including mid-instruction: core_state=IDLE, current_pc=START_PC, fetch_req=0, done=0, counters=0, internal wait counter=0. Reset has priority over every other input.
- IDLE: start=1 -> FETCH, current_pc<=START_PC. Otherwise stay.
- FETCH: fetch_req=1 combinationally while core_state==FETCH, 0 in all other states. fetch_valid=1 -> DECODE. Otherwise stay, with no timeout.
- DECODE: 1 cycle -> REQUEST.
- REQUEST: 1 cycle -> WAIT.
- WAIT with decoded_mem_access=0: 1 cycle -> EXECUTE.
- WAIT with decoded_mem_access=1: minimum 2 cycles, because lsu_busy is ignored in the first WAIT cycle (LSU issue cycle). From the 2nd WAIT cycle, exit to EXECUTE on the first cycle where lsu_busy==0 (all lanes idle).
- EXECUTE: 1 cycle -> UPDATE.
- UPDATE:
  - decoded_ret=1 -> DONE; PC unchanged.
  - Else decoded_branch=1 -> current_pc<=branch_target, then FETCH.
  - Else current_pc<=current_pc+1, wrapping 2^PC_BITS-1 -> 0, then FETCH.
  - decoded_ret has priority over decoded_branch.
- DONE: done=1, registered and asserted in the cycle core_state becomes DONE. start=1 -> FETCH, current_pc<=START_PC, done<=0.
- start is ignored in states FETCH..UPDATE.
- Best-case instruction (fetch_valid on the first FETCH cycle, no memory access): 6 cycles, FETCH through UPDATE.
- Decoded inputs are sampled only in WAIT and UPDATE; their values in other states are don't-care.

Optional Feature:
Macro SCHED_PERF_CNT_EN.
- Defined:
  - instr_retired increments on every UPDATE cycle, including RET.
  - stall_cycles increments on each FETCH cycle with fetch_valid=0, and on each WAIT cycle beyond the first.
  - Both counters saturate at 16'hFFFF and clear on reset and on any accepted start.
- Not defined: both ports are present and tied to 16'h0000, and no counter flops are synthesized.

Test Plan:
- Reset then start=1 with fetch_valid held 1, no mem, no branch/ret -> core_state sequence 000,001,010,011,100,101,110,001; current_pc goes 0->1 at the UPDATE edge.
- Memory stall: decoded_mem_access=1, lsu_busy=4'b0011 for 3 WAIT cycles then 4'b0000 -> 4 WAIT cycles, then EXECUTE; stall_cycles=3 with SCHED_PERF_CNT_EN.
- Branch and wrap: PC_BITS=8, current_pc=8'hFF, no branch -> PC 8'h00; next UPDATE with decoded_branch=1, branch_target=8'h40 -> PC 8'h40.
- RET priority: decoded_ret=1 and decoded_branch=1 in UPDATE -> DONE, done=1, PC unchanged; start=1 in DONE -> FETCH, PC=START_PC, done=0, instr_retired=0.
- Fetch stall: fetch_valid=0 for 5 cycles -> fetch_req held 1, state stays 001; start pulses during the stall are ignored.
- Reset mid-WAIT with lsu_busy=4'b1111 -> next cycle core_state=000, current_pc=START_PC, done=0, counters 0.
